// File: rtl/evr_rx_decoder_if.sv
`default_nettype none
//==============================================================================
// Interface : evr_rx_decoder_if
// Brief     : Recovered link word stream in, decoded event/timing outputs out.
// Revision  : 1.0 - initial release
//==============================================================================
interface evr_rx_decoder_if #(
    parameter int TOD_SECONDS_WIDTH     = 32,
    parameter int DISTRIBUTED_BUS_WIDTH = 8
);
    logic [15:0]                      evrRxData;
    logic [1:0]                       evrRxCharIsK;
    logic [7:0]                       evrEventTDATA;
    logic                             evrEventTVALID;
    logic [DISTRIBUTED_BUS_WIDTH-1:0] evrDistributedBus;
    logic [TOD_SECONDS_WIDTH-1:0]     evrSeconds;
    logic                             evrSecondsValid;
    logic                             evrPPSmarker;
    logic                             evrHeartbeat;
    logic                             evrLinkLocked;
    logic [15:0]                      evrCodeErrorCount;

    // Master is the link receiver side, slave is the decoder.
    modport master (
        output evrRxData, evrRxCharIsK,
        input  evrEventTDATA, evrEventTVALID, evrDistributedBus, evrSeconds,
               evrSecondsValid, evrPPSmarker, evrHeartbeat, evrLinkLocked,
               evrCodeErrorCount
    );

    modport slave (
        input  evrRxData, evrRxCharIsK,
        output evrEventTDATA, evrEventTVALID, evrDistributedBus, evrSeconds,
               evrSecondsValid, evrPPSmarker, evrHeartbeat, evrLinkLocked,
               evrCodeErrorCount
    );
endinterface
`default_nettype wire

// File: rtl/evr_rx_decoder.sv
`default_nettype none
//==============================================================================
// Module   : evr_rx_decoder
// Brief    : Comma alignment tracking, event/distributed-bus extraction and
//            seconds reconstruction for the event receiver.
// Revision : 1.0 - initial release
//==============================================================================
module evr_rx_decoder #(
    parameter int TOD_SECONDS_WIDTH     = 32,
    parameter int DISTRIBUTED_BUS_WIDTH = 8,
    parameter int COMMA_LOCK_COUNT      = 4,
    parameter int COMMA_TIMEOUT         = 2048
) (
    input  wire logic       evrRxClk,
    input  wire logic       evrRxResetN,
    evr_rx_decoder_if.slave evrBus
);

    localparam int c_lockCntWidth  = $clog2(COMMA_LOCK_COUNT + 1);
    localparam int c_toCntWidth    = $clog2(COMMA_TIMEOUT + 1);
    localparam int c_shiftCntWidth = $clog2(TOD_SECONDS_WIDTH + 2);

    localparam logic [c_lockCntWidth-1:0]  c_lockTarget    = c_lockCntWidth'(COMMA_LOCK_COUNT);
    localparam logic [c_lockCntWidth-1:0]  c_lockOne       = c_lockCntWidth'(1);
    localparam logic [c_toCntWidth-1:0]    c_timeoutTarget = c_toCntWidth'(COMMA_TIMEOUT);
    localparam logic [c_shiftCntWidth-1:0] c_shiftFull     = c_shiftCntWidth'(TOD_SECONDS_WIDTH);
    localparam logic [c_shiftCntWidth-1:0] c_shiftSat      = c_shiftCntWidth'(TOD_SECONDS_WIDTH + 1);

    localparam logic [1:0] c_stHunt    = 2'd0;
    localparam logic [1:0] c_stAcquire = 2'd1;
    localparam logic [1:0] c_stLocked  = 2'd2;

    logic [1:0]                       r_state;
    logic [c_lockCntWidth-1:0]        r_commaCnt;
    logic [c_toCntWidth-1:0]          r_timeoutCnt;
    logic [c_shiftCntWidth-1:0]       r_shiftCnt;
    logic [TOD_SECONDS_WIDTH-1:0]     r_shiftReg;
    logic [TOD_SECONDS_WIDTH-1:0]     r_seconds;
    logic                             r_secondsValid;
    logic [7:0]                       r_eventData;
    logic                             r_eventValid;
    logic [DISTRIBUTED_BUS_WIDTH-1:0] r_distBus;
    logic                             r_pps;
    logic                             r_heartbeat;
    logic                             r_linkLocked;
    logic [15:0]                      r_errCnt;

    logic [7:0]                       w_byte0;
    logic [7:0]                       w_byte1;
    logic                             w_isComma;
    logic                             w_isIllegal;
    logic                             w_isData;
    logic [c_lockCntWidth-1:0]        w_commaCntInc;
    logic [c_toCntWidth-1:0]          w_toCntInc;
    logic                             w_timeout;
    logic                             w_dropLink;
    logic [TOD_SECONDS_WIDTH-1:0]     w_shiftNext;

    assign w_byte0       = evrBus.evrRxData[7:0];
    assign w_byte1       = evrBus.evrRxData[15:8];
    assign w_isComma     = evrBus.evrRxCharIsK[0] && !evrBus.evrRxCharIsK[1] && (w_byte0 == 8'hBC);
    assign w_isIllegal   = evrBus.evrRxCharIsK[1] || (evrBus.evrRxCharIsK[0] && (w_byte0 != 8'hBC));
    assign w_isData      = (evrBus.evrRxCharIsK == 2'b00);
    assign w_commaCntInc = r_commaCnt + 1'b1;
    assign w_toCntInc    = r_timeoutCnt + 1'b1;
    assign w_timeout     = !w_isComma && (r_state != c_stHunt) && (w_toCntInc == c_timeoutTarget);
    assign w_dropLink    = (r_state != c_stHunt) && (w_isIllegal || w_timeout);

    // Code 0x70 shifts in 0, 0x71 shifts in 1: the new bit is byte0[0].
    generate
        if (TOD_SECONDS_WIDTH > 1) begin : g_shiftWide
            assign w_shiftNext = {r_shiftReg[TOD_SECONDS_WIDTH-2:0], w_byte0[0]};
        end else begin : g_shiftNarrow
            assign w_shiftNext = w_byte0[0];
        end
    endgenerate

    always_ff @(posedge evrRxClk) begin
        if (!evrRxResetN) begin
            r_state        <= c_stHunt;
            r_commaCnt     <= '0;
            r_timeoutCnt   <= '0;
            r_shiftCnt     <= '0;
            r_shiftReg     <= '0;
            r_seconds      <= '0;
            r_secondsValid <= 1'b0;
            r_eventData    <= '0;
            r_eventValid   <= 1'b0;
            r_distBus      <= '0;
            r_pps          <= 1'b0;
            r_heartbeat    <= 1'b0;
            r_linkLocked   <= 1'b0;
            r_errCnt       <= '0;
        end else begin
            r_eventValid <= 1'b0;
            r_pps        <= 1'b0;
            r_heartbeat  <= 1'b0;

            if ((r_state != c_stHunt) && w_isIllegal && (r_errCnt != 16'hFFFF)) begin
                r_errCnt <= r_errCnt + 16'd1;
            end

            case (r_state)
                c_stHunt: begin
                    if (w_isComma) begin
                        r_commaCnt   <= c_lockOne;
                        r_timeoutCnt <= '0;
                        if (COMMA_LOCK_COUNT == 1) begin
                            r_state      <= c_stLocked;
                            r_linkLocked <= 1'b1;
                        end else begin
                            r_state <= c_stAcquire;
                        end
                    end
                end

                c_stAcquire: begin
                    if (w_dropLink) begin
                        r_state      <= c_stHunt;
                        r_commaCnt   <= '0;
                        r_timeoutCnt <= '0;
                    end else if (w_isComma) begin
                        r_commaCnt   <= w_commaCntInc;
                        r_timeoutCnt <= '0;
                        if (w_commaCntInc == c_lockTarget) begin
                            r_state      <= c_stLocked;
                            r_linkLocked <= 1'b1;
                        end
                    end else begin
                        r_timeoutCnt <= w_toCntInc;
                    end
                end

                c_stLocked: begin
                    if (w_dropLink) begin
                        r_state        <= c_stHunt;
                        r_commaCnt     <= '0;
                        r_timeoutCnt   <= '0;
                        r_linkLocked   <= 1'b0;
                        r_distBus      <= '0;
                        r_secondsValid <= 1'b0;
                        r_shiftCnt     <= '0;
                    end else begin
                        r_timeoutCnt <= w_isComma ? '0 : w_toCntInc;
                        if (!evrBus.evrRxCharIsK[1]) begin
                            r_distBus <= w_byte1[DISTRIBUTED_BUS_WIDTH-1:0];
                        end
                        if (w_isData && (w_byte0 != 8'h00)) begin
                            r_eventData  <= w_byte0;
                            r_eventValid <= 1'b1;
                            case (w_byte0)
                                8'h70, 8'h71: begin
                                    r_shiftReg <= w_shiftNext;
                                    if (r_shiftCnt != c_shiftSat) begin
                                        r_shiftCnt <= r_shiftCnt + 1'b1;
                                    end
                                end
                                8'h7D: begin
                                    r_pps      <= 1'b1;
                                    r_shiftCnt <= '0;
                                    if (r_shiftCnt == c_shiftFull) begin
                                        r_seconds      <= r_shiftReg;
                                        r_secondsValid <= 1'b1;
                                    end else begin
                                        r_secondsValid <= 1'b0;
                                    end
                                end
                                8'h7A: r_heartbeat <= 1'b1;
                                default: ;
                            endcase
                        end
                    end
                end

                default: r_state <= c_stHunt;
            endcase
        end
    end

    assign evrBus.evrEventTDATA     = r_eventData;
    assign evrBus.evrEventTVALID    = r_eventValid;
    assign evrBus.evrDistributedBus = r_distBus;
    assign evrBus.evrSeconds        = r_seconds;
    assign evrBus.evrSecondsValid   = r_secondsValid;
    assign evrBus.evrPPSmarker      = r_pps;
    assign evrBus.evrHeartbeat      = r_heartbeat;
    assign evrBus.evrLinkLocked     = r_linkLocked;
    assign evrBus.evrCodeErrorCount = r_errCnt;

endmodule
`default_nettype wire

// File: doc/evr_rx_decoder.md
Name: evr_rx_decoder

Overview:
- Receive-side counterpart of the event generator transmit path.
- Takes the 16-bit recovered word stream from a link receiver and tracks comma alignment.
- Extracts event codes from byte 0 and the distributed bus from byte 1.
- Rebuilds the seconds value shifted in by codes 0x70/0x71, latches it on the seconds marker, and emits heartbeat/PPS strobes for downstream event-receiver logic.

Parameters:
- TOD_SECONDS_WIDTH, 32: width of the reconstructed seconds value (1..32).
- DISTRIBUTED_BUS_WIDTH, 8: number of byte-1 bits presented on evrDistributedBus (1..8); the LSBs of byte 1 are used.
- COMMA_LOCK_COUNT, 4: consecutive good commas required to declare lock (>=1).
- COMMA_TIMEOUT, 2048: maximum cycles between commas before lock is dropped (>=2).

Ports:
- evrRxClk  in  1  recovered receive clock; only clock in the block.
- evrRxResetN  in  1  synchronous, active-low reset on evrRxClk.
- evrRxData  in  16  received word; [7:0] event byte, [15:8] distributed-bus byte.
- evrRxCharIsK  in  2  K-character flags; [0] for byte 0, [1] for byte 1.
- evrEventTDATA  out  8  decoded event code.
- evrEventTVALID  out  1  one-cycle strobe, event code valid.
- evrDistributedBus  out  DISTRIBUTED_BUS_WIDTH  latched byte-1 bits.
- evrSeconds  out  TOD_SECONDS_WIDTH  last complete seconds value.
- evrSecondsValid  out  1  evrSeconds came from an exact-length shift sequence.
- evrPPSmarker  out  1  one-cycle strobe on code 0x7D.
- evrHeartbeat  out  1  one-cycle strobe on code 0x7A.
- evrLinkLocked  out  1  alignment state is LOCKED.
- evrCodeErrorCount  out  16  saturating count of illegal K characters.

Behaviour:
- Reset (evrRxResetN=0 at a clock edge):
  - All outputs go to 0; evrSeconds also clears to 0.
  - The state machine goes to HUNT; the shift register, shift count, comma count and timeout counter clear.
  - Reset takes priority over every other event.
- Latency: every output is registered and reflects the input word presented on the previous edge (1 cycle).
- Word classification:
  - Comma: CharIsK[0]=1, byte0=0xBC, CharIsK[1]=0.
  - Illegal: CharIsK[1]=1, or CharIsK[0]=1 with byte0 != 0xBC.
  - Data word: CharIsK=00.
- State machine:
  - HUNT: a comma moves to ACQUIRE with comma count=1. All other words are ignored.
  - ACQUIRE: each comma increments the comma count. When the count reaches COMMA_LOCK_COUNT, move to LOCKED. An illegal word or a timeout returns to HUNT.
  - LOCKED: an illegal word or a timeout returns to HUNT.
  - If COMMA_LOCK_COUNT=1, the first comma goes directly from HUNT to LOCKED.
- Timeout counter:
  - Cleared on every comma; increments on every other word while in ACQUIRE or LOCKED.
  - A timeout fires when the counter reaches COMMA_TIMEOUT.
- evrCodeErrorCount: increments by 1 on each illegal word in ACQUIRE or LOCKED; saturates at 0xFFFF; cleared only by reset.
- Decode while LOCKED only; outside LOCKED, no strobes and no bus updates:
  - Data word with byte0 != 0x00: evrEventTDATA=byte0 and evrEventTVALID=1 for one cycle. Special codes are forwarded as events too.
  - Byte 1 updates evrDistributedBus on any word with CharIsK[1]=0, including comma words. A comma word produces no event.
  - 0x70: shift register <= {sr[W-2:0],0}. 0x71: shift register <= {sr[W-2:0],1}. The value is built MSB-first. The shift count increments, saturating at W+1.
  - 0x7D: evrPPSmarker pulses.
    - If shift count == W exactly: evrSeconds <= shift register and evrSecondsValid <= 1.
    - Otherwise evrSeconds holds and evrSecondsValid <= 0.
    - The shift count clears in both cases.
  - 0x7A: evrHeartbeat pulses.
- Leaving LOCKED, on the same edge:
  - evrLinkLocked <= 0; evrDistributedBus <= 0; evrSecondsValid <= 0.
  - The shift count clears; evrSeconds holds.
  - If the word that caused the transition is illegal, it produces no event.

Test Plan:
1. Reset, then words 0x00BC with CharIsK=01 -> evrLinkLocked stays 0 after the 3rd comma and rises 1 cycle after the 4th; evrCodeErrorCount=0.
2. Locked; 32 codes encoding 0x12345678 MSB-first via 0x70/0x71, then 0x7D -> 33 TVALID pulses; evrPPSmarker pulses once; evrSeconds=0x12345678 and evrSecondsValid=1 one cycle after 0x7D.
3. Locked with evrSeconds=0x12345678; 31 shifts then 0x7D -> evrSecondsValid=0, evrSeconds stays 0x12345678; 33 shifts then 0x7D -> same result.
4. Locked; word 0xA52B with CharIsK=00 -> next cycle evrEventTDATA=0x2B, evrEventTVALID=1 for exactly one cycle, evrDistributedBus=0xA5; a following 0x3CBC comma -> bus=0x3C with no event.
5. Locked; word 0x1234 with CharIsK=10 -> evrLinkLocked=0, bus=0, evrCodeErrorCount=1, no event. Then 4 commas -> relocked.
6. COMMA_TIMEOUT=16; locked, then 16 data words 0x0000 with no comma -> evrLinkLocked falls after the 16th word; with evrRxResetN=0 mid-stream, all outputs read 0 on the next edge.
